// File: rtl/flash_pkg.sv
// Shared definitions for the flash controller arbiter: FSM state encoding,
// control/status word bit positions and the default controller address.
package flash_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        POLL  = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int CW_DONE    = 31;
    localparam int CW_RD      = 30;
    localparam int CW_WR      = 29;
    localparam int CW_BLK_MSB = 25;
    localparam int CW_BLK_W   = CW_BLK_MSB + 1;

    localparam logic [31:0] FLASH_CTRL_ADDR_DEFAULT = 32'hFFFF_FE00;

    // Command word: RD=op, WR=~op, block address in the low bits.
    function automatic logic [31:0] ctrl_word(input logic op, input logic [CW_BLK_W-1:0] blk);
        logic [31:0] w;
        w = '0;
        w[CW_RD] = op;
        w[CW_WR] = ~op;
        w[CW_BLK_MSB:0] = blk;
        return w;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie, the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/flash_arb.sv
// Arbitrates two block-transfer requesters onto one flash controller and
// drives its command/poll/clear handshake. Optional poll timeout: FLASH_ARB_TIMEOUT_EN.
module flash_arb
    import flash_pkg::*;
#(
    parameter logic [31:0] FLASH_CTRL_ADDR = FLASH_CTRL_ADDR_DEFAULT,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic                op0,
    input  logic                op1,
    input  logic [CW_BLK_W-1:0] blk0,
    input  logic [CW_BLK_W-1:0] blk1,
    output logic [1:0]          grant,
    output logic [1:0]          done,
    output logic [1:0]          err,
    output logic [31:0]         m_addr,
    output logic [31:0]         m_data_o,
    input  logic [31:0]         m_data_i,
    output logic                m_rd,
    output logic                m_we
);

    state_t              state_reg;
    logic                last_reg;
    logic                timed_out_reg;
    logic [1:0]          pick;
    logic                op_sel;
    logic [CW_BLK_W-1:0] blk_sel;
    logic                unused_bits;

    rr_arb2 u_rr (
        .req  (req),
        .last (last_reg),
        .pick (pick)
    );

    assign op_sel  = pick[1] ? op1  : op0;
    assign blk_sel = pick[1] ? blk1 : blk0;

    assign unused_bits = ^m_data_i[CW_DONE-1:0];

`ifdef FLASH_ARB_TIMEOUT_EN
    logic [31:0] cnt_reg;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign err = 2'b00;
`endif

    // Bus outputs are registered: each is loaded on the edge entering the
    // state that owns it, so they are valid for that state's whole cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant         <= 2'b00;
            done          <= 2'b00;
            last_reg      <= 1'b1;
            timed_out_reg <= 1'b0;
            m_addr        <= '0;
            m_data_o      <= '0;
            m_rd          <= 1'b0;
            m_we          <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
            err           <= 2'b00;
            cnt_reg       <= '0;
`endif
        end else begin
            done <= 2'b00;
`ifdef FLASH_ARB_TIMEOUT_EN
            err  <= 2'b00;
`endif
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        grant     <= pick;
                        m_we      <= 1'b1;
                        m_addr    <= FLASH_CTRL_ADDR;
                        m_data_o  <= ctrl_word(op_sel, blk_sel);
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_we      <= 1'b0;
                    m_data_o  <= '0;
                    m_rd      <= 1'b1;
                    state_reg <= POLL;
                end
                POLL: begin
                    if (m_data_i[CW_DONE]) begin
                        m_rd      <= 1'b0;
                        m_we      <= 1'b1;
                        state_reg <= CLEAR;
                    end
`ifdef FLASH_ARB_TIMEOUT_EN
                    else if (cnt_reg == TIMEOUT_CYCLES - 32'd1) begin
                        m_rd          <= 1'b0;
                        m_we          <= 1'b1;
                        timed_out_reg <= 1'b1;
                        state_reg     <= CLEAR;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
`endif
                end
                CLEAR: begin
                    m_we      <= 1'b0;
                    m_addr    <= '0;
                    done      <= timed_out_reg ? 2'b00 : grant;
`ifdef FLASH_ARB_TIMEOUT_EN
                    err       <= timed_out_reg ? grant : 2'b00;
`endif
                    state_reg <= DONE;
                end
                DONE: begin
                    grant         <= 2'b00;
                    last_reg      <= grant[1];
                    timed_out_reg <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
                    cnt_reg       <= '0;
`endif
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_arb.sv
// Scoreboard bench for flash_arb: stimulus pushes expected bus writes and
// completions; a negedge monitor pops and compares as the DUT presents them.
module tb_flash_arb;
    import flash_pkg::*;

    localparam logic [31:0] ADDR = 32'hFFFF_FE00;
`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int TO     = 8;
    localparam int POLL_A = 6;
`else
    localparam int TO     = 50_000_000;
    localparam int POLL_A = 10;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          polls;
    } wr_t;

    typedef struct {
        logic [1:0] grant;
        logic [1:0] done;
        logic [1:0] err;
    } cp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic        op0, op1;
    logic [25:0] blk0, blk1;
    logic [1:0]  grant, done, err;
    logic [31:0] m_addr, m_data_o, m_data_i;
    logic        m_rd, m_we;

    wr_t wr_q[$];
    cp_t cp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  mon_polls = 0;
    int  poll_target = 0;
    int  poll_seen = 0;
    int  lat;

    flash_arb #(
        .FLASH_CTRL_ADDR (ADDR),
        .TIMEOUT_CYCLES  (32'(TO))
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op0      (op0),
        .op1      (op1),
        .blk0     (blk0),
        .blk1     (blk1),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .m_addr   (m_addr),
        .m_data_o (m_data_o),
        .m_data_i (m_data_i),
        .m_rd     (m_rd),
        .m_we     (m_we)
    );

    always #5 clk = ~clk;

    // Flash controller model: status bit 31 appears on the poll_target-th poll.
    always @(posedge clk) begin
        if (rst || m_we) poll_seen <= 0;
        else if (m_rd)   poll_seen <= poll_seen + 1;
    end
    assign m_data_i = {(m_rd && poll_target != 0 && poll_seen >= poll_target - 1), 31'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_polls = 0;
        end else begin
            if (m_rd) mon_polls++;
            if (m_we) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual addr=%h data=%h expected none", m_addr, m_data_o);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", m_addr, w.addr);
                    chk("wr_data", m_data_o, w.data);
                    if (w.polls >= 0) chk("poll_count", 32'(mon_polls), 32'(w.polls));
                    $display("write addr=%h data=%h polls=%0d", m_addr, m_data_o, mon_polls);
                end
                mon_polls = 0;
            end
            if (done != 2'b00 || err != 2'b00) begin
                if (cp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cpl actual done=%b err=%b expected none", done, err);
                end else begin
                    cp_t c;
                    c = cp_q.pop_front();
                    chk("cpl_grant", 32'(grant), 32'(c.grant));
                    chk("cpl_done", 32'(done), 32'(c.done));
                    chk("cpl_err", 32'(err), 32'(c.err));
                    $display("complete grant=%b done=%b err=%b", grant, done, err);
                end
            end
        end
    end

    task automatic push_xfer(input logic [1:0] g, input logic [31:0] word, input int polls, input logic to);
        wr_q.push_back('{addr: ADDR, data: word, polls: -1});
        wr_q.push_back('{addr: ADDR, data: 32'h0, polls: polls});
        cp_q.push_back('{grant: g, done: to ? 2'b00 : g, err: to ? g : 2'b00});
    endtask

    task automatic wait_cpl(output int cycles);
        cycles = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cycles++;
            if (done != 2'b00 || err != 2'b00) return;
        end
        checks++; errors++;
        $display("FAIL cpl_wait actual=no completion expected=completion within 300 cycles");
    endtask

    task automatic wait_poll();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_rd) return;
        end
        checks++; errors++;
        $display("FAIL poll_wait actual=no poll expected=poll within 50 cycles");
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_bus_ctl"}, 32'({m_rd, m_we}), 32'h0);
        chk({tag, "_addr"}, m_addr, 32'h0);
        chk({tag, "_data"}, m_data_o, 32'h0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00;
        op0 = 1'b0; op1 = 1'b0; blk0 = '0; blk1 = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Both requesting from reset: alternating grants starting with 0.
        op0 = 1'b1; blk0 = 26'h55;
        op1 = 1'b0; blk1 = 26'h3FF_FFFF;
        poll_target = 3;
        push_xfer(2'b01, 32'h4000_0055, 3, 1'b0);
        push_xfer(2'b10, 32'h23FF_FFFF, 3, 1'b0);
        push_xfer(2'b01, 32'h4000_0055, 3, 1'b0);
        push_xfer(2'b10, 32'h23FF_FFFF, 3, 1'b0);
        req = 2'b11;
        for (int k = 0; k < 4; k++) wait_cpl(lat);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Single read of block 0x12 with a ten-poll wait.
        op0 = 1'b1; blk0 = 26'h12;
        poll_target = POLL_A;
        push_xfer(2'b01, 32'h4000_0012, POLL_A, 1'b0);
        req = 2'b01;
        wait_cpl(lat);
        chk("latency_a", 32'(lat), 32'(4 + POLL_A));
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Request dropped during POLL still completes.
        op0 = 1'b0; blk0 = 26'h2A;
        poll_target = 4;
        push_xfer(2'b01, 32'h2000_002A, 4, 1'b0);
        req = 2'b01;
        wait_poll();
        req = 2'b00;
        wait_cpl(lat);
        repeat (4) @(negedge clk);

        // Reset during POLL: no clear write, no completion.
        poll_target = 0;
        op0 = 1'b1; blk0 = 26'h7;
        wr_q.push_back('{addr: ADDR, data: 32'h4000_0007, polls: -1});
        req = 2'b01;
        wait_poll();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("mid_rst");
        rst = 1'b0; req = 2'b00;
        repeat (4) @(negedge clk);
        chk("mid_rst_idle_bus", 32'({m_rd, m_we}), 32'h0);

        // Minimum latency: status ready on the first poll.
        op1 = 1'b1; blk1 = 26'h0;
        poll_target = 1;
        push_xfer(2'b10, 32'h4000_0000, 1, 1'b0);
        req = 2'b10;
        wait_cpl(lat);
        chk("latency_min", 32'(lat), 32'd5);
        req = 2'b00;
        repeat (3) @(negedge clk);

`ifdef FLASH_ARB_TIMEOUT_EN
        // Status never ready: abort after TO polls and pulse err.
        poll_target = 0;
        op0 = 1'b0; blk0 = 26'h1;
        push_xfer(2'b01, 32'h2000_0001, TO, 1'b1);
        req = 2'b01;
        wait_cpl(lat);
        req = 2'b00;
        repeat (3) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("wr_q_empty", 32'(wr_q.size()), 32'h0);
        chk("cp_q_empty", 32'(cp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
